exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 34 +++
 rtl/exec_unit_alu.sv | 32 +++
 rtl/exec_unit.sv | 121 ++++++++++++
 tb/tb_exec_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// ============================================================================
// Module      : exec_unit_pkg
// Description : Opcodes, per-op latencies and FSM encoding shared by the
//               execution unit, reservation station and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_CDB = 2'd2
    } exec_state_t;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLT = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;

    localparam logic [1:0] LAT_MUL     = 2'd3;
    localparam logic [1:0] LAT_DEFAULT = 2'd1;

    // Unknown opcodes take the single-cycle path.
    function automatic logic [1:0] op_latency(input logic [4:0] op);
        return (op == OP_MUL) ? LAT_MUL : LAT_DEFAULT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_unit_alu.sv
// ============================================================================
// Module      : exec_alu
// Description : Purely combinational datapath for the execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu
    import exec_unit_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = 32'd0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:  result = a * b;
            default: result = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
// Module      : exec_unit
// Description : Single-issue execution unit: latches one instruction, runs it
//               for its latency, then holds the tagged result on the CDB
//               until the arbiter grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_unit
    import exec_unit_pkg::*;
#(
    parameter logic [4:0] RS_BASE = 5'd1
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        inValid,
    input  logic [4:0]  opIn,
    input  logic [31:0] dataIn1,
    input  logic [31:0] dataIn2,
    input  logic [4:0]  labelIn,
    output logic        exeReady,
    output logic        cdbReq,
    input  logic        cdbGrant,
    output logic        BCEN,
    output logic [4:0]  BClabel,
    output logic [31:0] BCdata
);

    exec_state_t state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  tag_q, tag_d;
    logic [31:0] result_q, result_d;

    logic [31:0] alu_result;
    logic        in_wait;

    // Only the low two slot bits select a station entry.
    logic unused_label_bits;
    assign unused_label_bits = ^labelIn[4:2];

    exec_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    op_d    = opIn;
                    a_d     = dataIn1;
                    b_d     = dataIn2;
                    tag_d   = RS_BASE + {3'b000, labelIn[1:0]};
                    cnt_d   = op_latency(opIn) - 2'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 2'd0) begin
                    result_d = alu_result;
                    state_d  = ST_WAIT_CDB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_WAIT_CDB: begin
                if (cdbGrant) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            op_q     <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            tag_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    // Bus outputs are zeroed outside WAIT_CDB so idle units never pollute the CDB.
    assign in_wait  = (state_q == ST_WAIT_CDB);
    assign exeReady = (state_q == ST_IDLE);
    assign cdbReq   = in_wait;
    assign BCEN     = in_wait & cdbGrant;
    assign BClabel  = in_wait ? tag_q    : 5'd0;
    assign BCdata   = in_wait ? result_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
// Module      : tb_exec_unit
// Description : Directed self-checking bench for exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_unit;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        inValid = 1'b0;
    logic [4:0]  opIn = 5'd0;
    logic [31:0] dataIn1 = 32'd0;
    logic [31:0] dataIn2 = 32'd0;
    logic [4:0]  labelIn = 5'd0;
    logic        cdbGrant = 1'b0;
    logic        exeReady;
    logic        cdbReq;
    logic        BCEN;
    logic [4:0]  BClabel;
    logic [31:0] BCdata;

    int total = 0;
    int bad = 0;

    exec_unit #(.RS_BASE(5'd1)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .inValid  (inValid),
        .opIn     (opIn),
        .dataIn1  (dataIn1),
        .dataIn2  (dataIn2),
        .labelIn  (labelIn),
        .exeReady (exeReady),
        .cdbReq   (cdbReq),
        .cdbGrant (cdbGrant),
        .BCEN     (BCEN),
        .BClabel  (BClabel),
        .BCdata   (BCdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] lbl);
        opIn    = op;
        dataIn1 = a;
        dataIn2 = b;
        labelIn = lbl;
        inValid = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; inValid = 1'b1; cdbGrant = 1'b1;
        drive(5'd0, 32'd1, 32'd1, 5'd0);
        tick();
        tick();
        total++; if (exeReady !== 1'b1) begin bad++; $display("FAIL reset_exeReady got=%b exp=1", exeReady); end
        total++; if (cdbReq !== 1'b0) begin bad++; $display("FAIL reset_cdbReq got=%b exp=0", cdbReq); end
        total++; if (BCEN !== 1'b0) begin bad++; $display("FAIL reset_BCEN got=%b exp=0", BCEN); end
        total++; if (BClabel !== 5'd0 || BCdata !== 32'd0) begin bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", BClabel, BCdata); end
        inValid = 1'b0; cdbGrant = 1'b0;
        nRST = 1'b1;
        tick();
        total++; if (exeReady !== 1'b1 || cdbReq !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b%b exp=10", exeReady, cdbReq); end
    endtask

    task automatic test_add();
        cdbGrant = 1'b1;
        drive(5'd0, 32'd5, 32'd7, 5'd2);
        total++; if (exeReady !== 1'b1) begin bad++; $display("FAIL add_ready_pre got=%b exp=1", exeReady); end
        tick();
        inValid = 1'b0;
        total++; if (exeReady !== 1'b0 || cdbReq !== 1'b0) begin bad++; $display("FAIL add_exec got=%b%b exp=00", exeReady, cdbReq); end
        tick();
        total++; if (cdbReq !== 1'b1 || BCEN !== 1'b1) begin bad++; $display("FAIL add_bcast got=%b%b exp=11", cdbReq, BCEN); end
        total++; if (BClabel !== 5'd3) begin bad++; $display("FAIL add_label got=%0d exp=3", BClabel); end
        total++; if (BCdata !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=0000000c", BCdata); end
        tick();
        total++; if (exeReady !== 1'b1 || BCEN !== 1'b0 || BClabel !== 5'd0 || BCdata !== 32'd0) begin
            bad++; $display("FAIL add_after got=%b%b %h %h exp=10 00 00000000", exeReady, BCEN, BClabel, BCdata); end
    endtask

    task automatic test_mul();
        int n;
        cdbGrant = 1'b1;
        drive(5'd5, 32'hFFFF_FFFF, 32'd2, 5'd1);
        tick();
        inValid = 1'b0;
        n = 0;
        while (BCEN !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++; if (n != 3) begin bad++; $display("FAIL mul_latency got=%0d exp=3", n); end
        total++; if (BCdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_data got=%h exp=fffffffe", BCdata); end
        total++; if (BClabel !== 5'd2) begin bad++; $display("FAIL mul_label got=%0d exp=2", BClabel); end
        tick();
    endtask

    task automatic test_sub_stall();
        cdbGrant = 1'b0;
        drive(5'd1, 32'd3, 32'd5, 5'd0);
        tick();
        inValid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cdbReq !== 1'b1 || BCEN !== 1'b0 || exeReady !== 1'b0 || BCdata !== 32'hFFFF_FFFE || BClabel !== 5'd1) begin
                bad++;
                $display("FAIL sub_stall[%0d] got req=%b en=%b rdy=%b lbl=%0d data=%h exp req=1 en=0 rdy=0 lbl=1 data=fffffffe",
                         i, cdbReq, BCEN, exeReady, BClabel, BCdata);
            end
            tick();
        end
        cdbGrant = 1'b1;
        #1;
        total++; if (BCEN !== 1'b1 || BCdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_grant got=%b %h exp=1 fffffffe", BCEN, BCdata); end
        tick();
        total++; if (BCEN !== 1'b0 || exeReady !== 1'b1 || cdbReq !== 1'b0) begin
            bad++; $display("FAIL sub_idle_grant_ignored got en=%b rdy=%b req=%b exp 0 1 0", BCEN, exeReady, cdbReq); end
        cdbGrant = 1'b0;
    endtask

    task automatic test_ops();
        logic [4:0]  ops  [6];
        logic [31:0] va   [6];
        logic [31:0] vb   [6];
        logic [4:0]  lbls [6];
        logic [31:0] exp_d[6];
        logic [4:0]  exp_l[6];
        ops  = '{5'd4, 5'd4, 5'd2, 5'd3, 5'd31, 5'd0};
        va   = '{32'hFFFF_FFFF, 32'd1, 32'hF0F0_1234, 32'hF000_000F, 32'd5, 32'hFFFF_FFFF};
        vb   = '{32'd1, 32'hFFFF_FFFF, 32'h0FF0_FF00, 32'h0000_0F00, 32'd7, 32'd2};
        lbls = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd2, 5'd3};
        exp_d= '{32'd1, 32'd0, 32'h00F0_1200, 32'hF000_0F0F, 32'd0, 32'd1};
        exp_l= '{5'd1, 5'd2, 5'd4, 5'd4, 5'd3, 5'd4};
        cdbGrant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], va[i], vb[i], lbls[i]);
            tick();
            inValid = 1'b0;
            tick();
            total++;
            if (BCEN !== 1'b1 || BClabel !== exp_l[i] || BCdata !== exp_d[i]) begin
                bad++;
                $display("FAIL op[%0d] op=%0d got en=%b lbl=%0d data=%h exp en=1 lbl=%0d data=%h",
                         i, ops[i], BCEN, BClabel, BCdata, exp_l[i], exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        cdbGrant = 1'b1;
        drive(5'd5, 32'd6, 32'd7, 5'd1);
        tick();
        inValid = 1'b0;
        tick();
        nRST = 1'b0;
        tick();
        total++; if (exeReady !== 1'b1 || cdbReq !== 1'b0 || BCEN !== 1'b0 || BClabel !== 5'd0 || BCdata !== 32'd0) begin
            bad++; $display("FAIL midreset_outputs got rdy=%b req=%b en=%b lbl=%0d data=%h exp 1 0 0 0 0",
                            exeReady, cdbReq, BCEN, BClabel, BCdata); end
        nRST = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (BCEN === 1'b1 || cdbReq === 1'b1) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_bcast got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        cdbGrant = 1'b1;
        drive(5'd0, 32'd1, 32'd2, 5'd1);
        tick();
        drive(5'd1, 32'd100, 32'd200, 5'd3);
        tick();
        total++; if (BCEN !== 1'b1 || BCdata !== 32'd3 || BClabel !== 5'd2) begin
            bad++; $display("FAIL b2b_first got en=%b lbl=%0d data=%h exp 1 2 00000003", BCEN, BClabel, BCdata); end
        tick();
        total++; if (exeReady !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", exeReady); end
        tick();
        inValid = 1'b0;
        total++; if (exeReady !== 1'b0) begin bad++; $display("FAIL b2b_second_issue got=%b exp=0", exeReady); end
        tick();
        total++; if (BCEN !== 1'b1 || BCdata !== 32'hFFFF_FF9C || BClabel !== 5'd4) begin
            bad++; $display("FAIL b2b_second got en=%b lbl=%0d data=%h exp 1 4 ffffff9c", BCEN, BClabel, BCdata); end
        tick();
        cdbGrant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_sub_stall();
        test_ops();
        test_reset_midflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
